// File: rtl/l2_responder.sv
// ---------------------------------------------------------------------------
// l2_responder
//
// Direct-mapped L2 cache controller that sits between an L1 and a line-wide
// backing memory.
// 256 sets of 128-bit lines with write-back and write-allocate.
// Line address A = {tag, index} (26 b): set = A[7:0], stored tag = A[25:8].
//
// Ports
//   clk          : sole clock, rising edge
//   rst          : synchronous, active-high reset
//   read_L1_L2   : L1 line-read request (level, held until ready_L2_L1)
//   write_L1_L2  : L1 write-back request (level, held until ready_L2_L1)
//   tag, index   : L1 tag (20 b) / index (6 b) of the requested line
//   wdata_L1_L2  : line data for writes
//   ready_L2_L1  : one-cycle completion pulse to L1
//   rdata_L2_L1  : read data, valid with ready_L2_L1, held until next read
//   mem_read     : memory fill request (level, held until mem_ready)
//   mem_write    : memory write-back request (level, held until mem_ready)
//   mem_addr     : memory line address
//   mem_wdata    : victim line for write-back
//   mem_rdata    : fill data, valid with mem_ready
//   mem_ready    : one-cycle memory completion pulse
// ---------------------------------------------------------------------------
module l2_responder (
  input  logic         clk,
  input  logic         rst,
  input  logic         read_L1_L2,
  input  logic         write_L1_L2,
  input  logic [19:0]  tag,
  input  logic [5:0]   index,
  input  logic [127:0] wdata_L1_L2,
  output logic         ready_L2_L1,
  output logic [127:0] rdata_L2_L1,
  output logic         mem_read,
  output logic         mem_write,
  output logic [25:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITE_BACK,
    S_ALLOCATE,
    S_RESPOND
  } state_t;

  state_t         state_reg;
  logic [25:0]    addr_reg;
  logic           op_write_reg;
  logic [127:0]   wdata_reg;
  logic [255:0]   valid_reg;
  logic [255:0]   dirty_reg;
  logic           ready_reg;
  logic [127:0]   rdata_reg;
  logic           mem_read_reg;
  logic           mem_write_reg;
  logic [25:0]    mem_addr_reg;
  logic [127:0]   mem_wdata_reg;

  // Line storage: block-RAM style arrays with a registered read port.
  logic [127:0]   data_mem [0:255];
  logic [17:0]    tag_mem  [0:255];
  logic [127:0]   data_q;
  logic [17:0]    tag_q;

  logic [25:0]    req_addr;
  logic [7:0]     cur_set;
  logic [17:0]    cur_tag;
  logic [7:0]     rd_set;
  logic           hit;
  logic           victim_dirty;
  logic           ram_we;
  logic [127:0]   ram_wdata;

  assign req_addr = {tag, index};
  assign cur_set  = addr_reg[7:0];
  assign cur_tag  = addr_reg[25:8];

  always_comb begin
    // In IDLE the RAM is addressed straight from the request inputs so the
    // set's tag/data are already registered when COMPARE is entered.
    rd_set       = (state_reg == S_IDLE) ? req_addr[7:0] : cur_set;
    hit          = valid_reg[cur_set] && (tag_q == cur_tag);
    victim_dirty = valid_reg[cur_set] && dirty_reg[cur_set];
    ram_we       = 1'b0;
    ram_wdata    = wdata_reg;
    if (state_reg == S_COMPARE && op_write_reg && (hit || !victim_dirty)) begin
      ram_we = 1'b1;
    end
    if (state_reg == S_ALLOCATE && mem_ready) begin
      ram_we    = 1'b1;
      ram_wdata = mem_rdata;
    end
  end

  // Write-first RAM: a fill makes the new line visible on the very next
  // cycle, so the re-compare after ALLOCATE sees the installed tag and data.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      data_mem[cur_set] <= ram_wdata;
      tag_mem[cur_set]  <= cur_tag;
      data_q            <= ram_wdata;
      tag_q             <= cur_tag;
    end else begin
      data_q <= data_mem[rd_set];
      tag_q  <= tag_mem[rd_set];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      ready_reg     <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      valid_reg     <= '0;
      dirty_reg     <= '0;
    end else begin
      ready_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // The ready pulse is presented while already back in IDLE; L1 still
          // holds its request during that cycle, so it must not be re-taken.
          if (!ready_reg && (write_L1_L2 || read_L1_L2)) begin
            addr_reg     <= req_addr;
            op_write_reg <= write_L1_L2;  // write wins when both are high
            wdata_reg    <= wdata_L1_L2;
            state_reg    <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (hit) begin
            if (op_write_reg) begin
              dirty_reg[cur_set] <= 1'b1;
            end else begin
              rdata_reg <= data_q;
            end
            state_reg <= S_RESPOND;
          end else if (victim_dirty) begin
            mem_write_reg <= 1'b1;
            mem_addr_reg  <= {tag_q, cur_set};
            mem_wdata_reg <= data_q;
            state_reg     <= S_WRITE_BACK;
          end else if (op_write_reg) begin
            // Write miss on a clean/empty set: install directly, no fill.
            valid_reg[cur_set] <= 1'b1;
            dirty_reg[cur_set] <= 1'b1;
            state_reg          <= S_RESPOND;
          end else begin
            mem_read_reg <= 1'b1;
            mem_addr_reg <= addr_reg;
            state_reg    <= S_ALLOCATE;
          end
        end
        S_WRITE_BACK: begin
          if (mem_ready) begin
            mem_write_reg      <= 1'b0;
            dirty_reg[cur_set] <= 1'b0;
            if (op_write_reg) begin
              state_reg <= S_COMPARE;
            end else begin
              mem_read_reg <= 1'b1;
              mem_addr_reg <= addr_reg;
              state_reg    <= S_ALLOCATE;
            end
          end
        end
        S_ALLOCATE: begin
          if (mem_ready) begin
            mem_read_reg       <= 1'b0;
            valid_reg[cur_set] <= 1'b1;
            dirty_reg[cur_set] <= 1'b0;
            state_reg          <= S_COMPARE;
          end
        end
        S_RESPOND: begin
          ready_reg <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign ready_L2_L1 = ready_reg;
  assign rdata_L2_L1 = rdata_reg;
  assign mem_read    = mem_read_reg;
  assign mem_write   = mem_write_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;

endmodule

// File: tb/tb_l2_responder.sv
module tb_l2_responder;

  logic         clk;
  logic         rst;
  logic         read_L1_L2;
  logic         write_L1_L2;
  logic [19:0]  tag;
  logic [5:0]   index;
  logic [127:0] wdata_L1_L2;
  logic         ready_L2_L1;
  logic [127:0] rdata_L2_L1;
  logic         mem_read;
  logic         mem_write;
  logic [25:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int checks;
  int failures;

  l2_responder dut (
    .clk         (clk),
    .rst         (rst),
    .read_L1_L2  (read_L1_L2),
    .write_L1_L2 (write_L1_L2),
    .tag         (tag),
    .index       (index),
    .wdata_L1_L2 (wdata_L1_L2),
    .ready_L2_L1 (ready_L2_L1),
    .rdata_L2_L1 (rdata_L2_L1),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           rd;
    bit           wr;
    logic [19:0]  t;
    logic [5:0]   i;
    logic [127:0] wd;
    bit           exp_wb;
    logic [25:0]  wb_addr;
    logic [127:0] wb_data;
    bit           exp_fill;
    logic [25:0]  fill_addr;
    logic [127:0] fill_data;
    bit           chk_rdata;
    logic [127:0] rdata;
    int           lat;
  } vec_t;

  typedef struct {
    bit           is_wr;
    logic [25:0]  addr;
    logic [127:0] data;
  } mem_exp_t;

  typedef struct {
    bit           chk;
    logic [127:0] data;
    int           lat;
  } rsp_exp_t;

  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];
  vec_t     vecs[$];

  localparam logic [127:0] D_A5 = {16{8'hA5}};
  localparam logic [127:0] D_11 = {16{8'h11}};
  localparam logic [127:0] D_5A = {16{8'h5A}};
  localparam logic [127:0] D_C3 = {16{8'hC3}};
  localparam logic [127:0] D_3C = {16{8'h3C}};
  localparam logic [127:0] D_77 = {16{8'h77}};
  localparam logic [127:0] D_99 = {16{8'h99}};
  localparam logic [127:0] D_E1 = {16{8'hE1}};

  function automatic vec_t mk(bit rd, bit wr, logic [19:0] t, logic [5:0] i,
                              logic [127:0] wd, bit ewb, logic [25:0] wba,
                              logic [127:0] wbd, bit efl, logic [25:0] fla,
                              logic [127:0] fld, bit chk, logic [127:0] rdat,
                              int lat);
    vec_t v;
    v.rd = rd; v.wr = wr; v.t = t; v.i = i; v.wd = wd;
    v.exp_wb = ewb; v.wb_addr = wba; v.wb_data = wbd;
    v.exp_fill = efl; v.fill_addr = fla; v.fill_data = fld;
    v.chk_rdata = chk; v.rdata = rdat; v.lat = lat;
    return v;
  endfunction

  // Drive one L1 request, service memory from the scoreboard, check response.
  // Entered and left on a negative clock edge.
  task automatic do_txn(input int id, input vec_t v);
    mem_exp_t me;
    rsp_exp_t re;
    int cyc;
    int wait_cnt;
    bit got;
    bit both;
    if (v.exp_wb) begin
      me.is_wr = 1'b1; me.addr = v.wb_addr; me.data = v.wb_data;
      mem_q.push_back(me);
    end
    if (v.exp_fill) begin
      me.is_wr = 1'b0; me.addr = v.fill_addr; me.data = v.fill_data;
      mem_q.push_back(me);
    end
    re.chk = v.chk_rdata; re.data = v.rdata; re.lat = v.lat;
    rsp_q.push_back(re);

    read_L1_L2  = v.rd;
    write_L1_L2 = v.wr;
    tag         = v.t;
    index       = v.i;
    wdata_L1_L2 = v.wd;
    cyc = 0; wait_cnt = 0; got = 1'b0; both = 1'b0;
    while (!got && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (mem_read && mem_write) both = 1'b1;
      if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (mem_read || mem_write) begin
        wait_cnt++;
        if (wait_cnt == 1) begin
          checks++;
          if (mem_q.size() == 0) begin
            failures++;
            $display("FAIL txn%0d unexpected_mem_op rd=%0b wr=%0b addr=%h required none",
                     id, mem_read, mem_write, mem_addr);
          end else begin
            me = mem_q.pop_front();
            if (mem_write !== me.is_wr || mem_addr !== me.addr) begin
              failures++;
              $display("FAIL txn%0d mem_op got wr=%0b addr=%h required wr=%0b addr=%h",
                       id, mem_write, mem_addr, me.is_wr, me.addr);
            end
            if (me.is_wr) begin
              checks++;
              if (mem_wdata !== me.data) begin
                failures++;
                $display("FAIL txn%0d mem_wdata got %h required %h", id, mem_wdata, me.data);
              end
            end else begin
              mem_rdata = me.data;
            end
          end
        end
        if (wait_cnt == 3) begin
          mem_ready = 1'b1;
          wait_cnt  = 0;
        end
      end
      if (ready_L2_L1) begin
        got = 1'b1;
        re = rsp_q.pop_front();
        if (re.chk) begin
          checks++;
          if (rdata_L2_L1 !== re.data) begin
            failures++;
            $display("FAIL txn%0d rdata got %h required %h", id, rdata_L2_L1, re.data);
          end
        end
        if (re.lat != 0) begin
          checks++;
          if (cyc - 1 != re.lat) begin
            failures++;
            $display("FAIL txn%0d latency got %0d required %0d", id, cyc - 1, re.lat);
          end
        end
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL txn%0d ready_timeout got no ready required ready within 200 cycles", id);
      rsp_q.delete();
    end
    read_L1_L2  = 1'b0;
    write_L1_L2 = 1'b0;
    mem_ready   = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_L2_L1 !== 1'b0) begin
      failures++;
      $display("FAIL txn%0d ready_pulse_width got ready=%0b required 0", id, ready_L2_L1);
    end
    checks++;
    if (mem_q.size() != 0) begin
      failures++;
      $display("FAIL txn%0d missing_mem_ops got %0d outstanding required 0", id, mem_q.size());
      mem_q.delete();
    end
    checks++;
    if (both) begin
      failures++;
      $display("FAIL txn%0d mem_rd_wr_together got both high required exclusive", id);
    end
    $display("txn%0d rd=%0b wr=%0b tag=%h idx=%h cycles=%0d rdata=%h",
             id, v.rd, v.wr, v.t, v.i, cyc, rdata_L2_L1);
  endtask

  initial begin
    bit saw;
    checks = 0; failures = 0;
    rst = 1'b1; read_L1_L2 = 1'b0; write_L1_L2 = 1'b0;
    tag = '0; index = '0; wdata_L1_L2 = '0;
    mem_rdata = '0; mem_ready = 1'b0;

    // Cold read, repeat hit, write hit, dirty eviction, write misses, both-high.
    vecs.push_back(mk(1,0,20'h00001,6'h05,'0,   0,'0,'0,       1,26'h0000045,D_A5, 1,D_A5,0));
    vecs.push_back(mk(1,0,20'h00001,6'h05,'0,   0,'0,'0,       0,'0,'0,            1,D_A5,2));
    vecs.push_back(mk(0,1,20'h00001,6'h05,D_11, 0,'0,'0,       0,'0,'0,            0,'0,  2));
    vecs.push_back(mk(1,0,20'h00001,6'h05,'0,   0,'0,'0,       0,'0,'0,            1,D_11,2));
    vecs.push_back(mk(1,0,20'h00101,6'h05,'0,   1,26'h0000045,D_11, 1,26'h0004045,D_5A, 1,D_5A,0));
    vecs.push_back(mk(1,0,20'h00001,6'h05,'0,   0,'0,'0,       1,26'h0000045,D_11, 1,D_11,0));
    vecs.push_back(mk(0,1,20'h00002,6'h3F,D_C3, 0,'0,'0,       0,'0,'0,            0,'0,  2));
    vecs.push_back(mk(1,0,20'h00002,6'h3F,'0,   0,'0,'0,       0,'0,'0,            1,D_C3,2));
    vecs.push_back(mk(0,1,20'h00006,6'h3F,D_3C, 1,26'h00000BF,D_C3, 0,'0,'0,       0,'0,  0));
    vecs.push_back(mk(1,0,20'h00006,6'h3F,'0,   0,'0,'0,       0,'0,'0,            1,D_3C,2));
    vecs.push_back(mk(1,1,20'h00003,6'h10,D_77, 0,'0,'0,       0,'0,'0,            0,'0,  2));
    vecs.push_back(mk(1,0,20'h00003,6'h10,'0,   0,'0,'0,       0,'0,'0,            1,D_77,2));

    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready_L2_L1 !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%0b mem_read=%0b mem_write=%0b required 0 0 0",
               ready_L2_L1, mem_read, mem_write);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < vecs.size(); k++) begin
      do_txn(k, vecs[k]);
    end

    // Reset while a fill is outstanding: request must drop, no ready pulse.
    read_L1_L2 = 1'b1; write_L1_L2 = 1'b0; tag = 20'h00007; index = 6'h01;
    saw = 1'b0;
    for (int c = 0; c < 20 && !saw; c++) begin
      @(negedge clk);
      if (mem_read) saw = 1'b1;
    end
    checks++;
    if (!saw || mem_addr !== 26'h00001C1) begin
      failures++;
      $display("FAIL rst_alloc_fill got mem_read=%0b addr=%h required 1 00001c1", saw, mem_addr);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || ready_L2_L1 !== 1'b0) begin
      failures++;
      $display("FAIL rst_abandon got mem_read=%0b mem_write=%0b ready=%0b required 0 0 0",
               mem_read, mem_write, ready_L2_L1);
    end
    rst = 1'b0;
    read_L1_L2 = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ready_L2_L1 || mem_read || mem_write) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      failures++;
      $display("FAIL rst_quiet got activity after reset required none");
    end
    $display("rst_during_allocate done");

    // After reset the interrupted line and the previously cached line both miss.
    do_txn(100, mk(1,0,20'h00007,6'h01,'0, 0,'0,'0, 1,26'h00001C1,D_99, 1,D_99,0));
    do_txn(101, mk(1,0,20'h00001,6'h05,'0, 0,'0,'0, 1,26'h0000045,D_E1, 1,D_E1,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
